ahb_apb_bridge: RTL and testbench
=================================

AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 Parameter SLOT_LSB, default 8: LSB of the 4-bit HADDR field that selects the APB slot.
REQ-002 HCLK  in  1  single clock for both the AHB and APB sides (PCLK is HCLK).
REQ-003 HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 HSEL  in  1  bridge selected by the AHB decoder.
REQ-005 HADDR  in  32  AHB address.
REQ-006 HTRANS  in  2  transfer type; only 2'b10 and 2'b11 are valid.
REQ-007 HWRITE  in  1  1 = write.
REQ-008 HSIZE  in  3  ignored; all accesses are 32-bit.
REQ-009 HREADY  in  1  bus-level ready.
REQ-010 HWDATA  in  32  AHB write data.
REQ-011 HREADYOUT  out  1  bridge ready.
REQ-012 HRESP  out  1  1 = ERROR.
REQ-013 HRDATA  out  32  AHB read data.
REQ-014 PADDR  out  32  APB address.
REQ-015 PSEL  out  16  one-hot APB slot select.
REQ-016 PENABLE  out  1  APB access phase.
REQ-017 PWRITE  out  1  APB direction.
REQ-018 PWDATA  out  32  APB write data.
REQ-019 PRDATA  in  32  read data, already muxed from the selected slave.
REQ-020 PREADY  in  1  selected slave ready.
REQ-021 PSLVERR  in  1  selected slave error.

Function
REQ-022 The bridge SHALL implement an FSM with states IDLE, SETUP, ACCESS, ERR1 and ERR2.
REQ-023 Transfer capture SHALL occur when HSEL & HREADY & HTRANS[1] = 1; BUSY and IDLE HTRANS values SHALL be ignored.
REQ-024 On capture, the bridge SHALL register HADDR into PADDR and HWRITE into PWRITE, and SHALL register the slot index HADDR[SLOT_LSB+3:SLOT_LSB].
REQ-025 Capture SHALL be legal in IDLE, in ACCESS when PREADY=1 and PSLVERR=0, and in ERR2; the next state on capture SHALL be SETUP.
REQ-026 In those same states without a capture, the next state SHALL be IDLE.
REQ-027 SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0; the next state SHALL always be ACCESS.
REQ-028 ACCESS: PSEL[slot]=1 and PENABLE=1.
REQ-029 ACCESS with PREADY=0: stay in ACCESS with HREADYOUT=0, and hold PADDR, PWRITE and PSEL stable.
REQ-030 ACCESS with PREADY=1 and PSLVERR=0: HREADYOUT=1 and HRESP=0; the transfer completes this cycle.
REQ-031 ACCESS with PREADY=1 and PSLVERR=1: HREADYOUT=0 and HRESP=1, with next state ERR1.
REQ-032 ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1; the next state SHALL be ERR2.
REQ-033 ERR2: HREADYOUT=1 and HRESP=1, completing the AHB two-cycle error response.
REQ-034 PWDATA SHALL equal HWDATA combinationally, because the AHB master holds HWDATA stable while HREADYOUT=0.
REQ-035 HRDATA SHALL equal PRDATA combinationally; HRDATA is meaningful only in the ACCESS completion cycle of a read.
REQ-036 PSEL SHALL be all-zero in IDLE, ERR1 and ERR2, and at most one PSEL bit SHALL be set at any time.
REQ-037 IDLE: HREADYOUT=1, HRESP=0, PENABLE=0.
REQ-038 Latency with zero-wait slaves: address phase at T0, SETUP at T1 with HREADYOUT=0, ACCESS at T2 with HREADYOUT=1, giving exactly one AHB wait state.
REQ-039 Each PREADY=0 cycle in ACCESS SHALL add one AHB wait state.
REQ-040 Back-to-back transfers: an address phase that coincides with ACCESS completion SHALL enter SETUP on the next cycle with no IDLE gap, and PADDR SHALL update at that edge.
REQ-041 If a slave error occurs while the master has a new address pending, the pending transfer SHALL NOT be captured in ACCESS or ERR1; it is captured only in ERR2, if the master still presents it.

Reset
REQ-042 Asserting HRESETn low SHALL immediately force, from any state including mid-ACCESS: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, HREADYOUT=1, HRESP=0.
REQ-043 Any in-flight transfer SHALL be abandoned on reset, with no APB completion.
REQ-044 The first capture SHALL be possible on the first rising HCLK edge after HRESETn deasserts.

Verification
REQ-045 Write: HADDR=0x4000_0304, HWDATA=0xA5, PREADY=1 -> T1 PSEL=0x0008, PENABLE=0, PWDATA=0xA5; T2 PENABLE=1, HREADYOUT=1.
REQ-046 Read with wait states: PRDATA=0x5A, PREADY low for 3 ACCESS cycles -> HREADYOUT low for 4 cycles, then HRDATA=0x5A with HREADYOUT=1.
REQ-047 Error: PSLVERR=1 with PREADY=1 -> HRESP=1 for 3 cycles with HREADYOUT pattern 0,0,1; PSEL=0 in ERR1/ERR2.
REQ-048 Back-to-back: write to slot 2 followed immediately by read from slot 5 -> PSEL goes 0x0004 to 0x0020 with no IDLE cycle between; 4 cycles total at zero wait.
REQ-049 Reset mid-ACCESS: HRESETn low while PREADY=0 -> same-cycle PSEL=0, PENABLE=0, HREADYOUT=1, with no clock edge required.
REQ-050 Ignored transfers: HTRANS=BUSY or HSEL=0 -> PSEL remains 0 and HREADYOUT remains 1.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge on a single clock. Each AHB transfer is converted into one
// APB SETUP/ACCESS sequence. A slave error is returned as the two-cycle AHB ERROR response.
module ahb_apb_bridge #(
    parameter int unsigned SLOT_LSB = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] PADDR,
    output logic [15:0] PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [3:0]  slot_q, slot_d;

    logic capture;
    logic accept;

    // HSIZE is ignored (all accesses are 32-bit). HTRANS[0] only separates NONSEQ from SEQ.
    logic unused_inputs;
    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    // NONSEQ and SEQ have HTRANS[1] set. IDLE and BUSY have it clear.
    assign capture = HSEL & HREADY & HTRANS[1];

    // Write data and read data pass straight through.
    // The master holds HWDATA stable while the bridge stalls.
    assign PWDATA = HWDATA;
    assign HRDATA = PRDATA;
    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;

    // A new address phase is accepted only where the AHB side sees a completing cycle.
    always_comb begin
        accept = 1'b0;
        unique case (state_q)
            StIdle, StErr2: accept = 1'b1;
            StAccess:       accept = PREADY & ~PSLVERR;
            default:        accept = 1'b0;
        endcase
    end

    // State register and captured transfer attributes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            slot_q   <= slot_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StErr2: state_d = capture ? StSetup : StIdle;
            StSetup:        state_d = StAccess;
            StAccess: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = StErr1;
                    end else begin
                        state_d = capture ? StSetup : StIdle;
                    end
                end
            end
            StErr1:         state_d = StErr2;
            default:        state_d = StIdle;
        endcase
    end

    // Address, direction and slot load on an accepted capture and hold otherwise.
    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        slot_d   = slot_q;
        if (accept && capture) begin
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
            slot_d   = HADDR[SLOT_LSB +: 4];
        end
    end

    // Output decode from the current state.
    // ACCESS looks at the slave handshake within the same cycle.
    always_comb begin
        PSEL      = '0;
        PENABLE   = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            StIdle: begin
                HREADYOUT = 1'b1;
            end
            StSetup: begin
                PSEL      = 16'h0001 << slot_q;
                HREADYOUT = 1'b0;
            end
            StAccess: begin
                PSEL      = 16'h0001 << slot_q;
                PENABLE   = 1'b1;
                HREADYOUT = PREADY & ~PSLVERR;
                HRESP     = PREADY & PSLVERR;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge.
// A transaction-level model is checked against the outputs at every falling edge.
// Directed sequences use literal expectations.
module tb_ahb_apb_bridge;

    localparam int unsigned SLOT_LSB = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] PADDR;
    logic [15:0] PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    ahb_apb_bridge #(.SLOT_LSB(SLOT_LSB)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model.
    // A transfer is either absent, waiting for its setup cycle, or in its access phase.
    // An error response counts down two cycles.
    logic        m_active;
    logic        m_in_access;
    int          m_err_left;
    logic [31:0] m_addr;
    logic        m_write;

    logic [15:0] e_psel;
    logic        e_pen;
    logic        e_hrdy;
    logic        e_hresp;
    logic        e_rd_done;
    logic        take;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            m_active    = 1'b0;
            m_in_access = 1'b0;
            m_err_left  = 0;
            m_addr      = 32'h0;
            m_write     = 1'b0;
            check("rst_psel",    32'(PSEL),      32'h0);
            check("rst_penable", 32'(PENABLE),   32'h0);
            check("rst_hready",  32'(HREADYOUT), 32'h1);
            check("rst_hresp",   32'(HRESP),     32'h0);
            check("rst_paddr",   PADDR,          32'h0);
            check("rst_pwrite",  32'(PWRITE),    32'h0);
        end else begin
            e_psel    = 16'h0;
            e_pen     = 1'b0;
            e_hrdy    = 1'b1;
            e_hresp   = 1'b0;
            e_rd_done = 1'b0;
            if (m_err_left == 2) begin
                e_hrdy  = 1'b0;
                e_hresp = 1'b1;
            end else if (m_err_left == 1) begin
                e_hrdy  = 1'b1;
                e_hresp = 1'b1;
            end else if (m_active) begin
                e_psel = 16'(1 << ((m_addr >> SLOT_LSB) % 16));
                if (!m_in_access) begin
                    e_hrdy = 1'b0;
                end else begin
                    e_pen     = 1'b1;
                    e_hrdy    = PREADY && !PSLVERR;
                    e_hresp   = PREADY && PSLVERR;
                    e_rd_done = PREADY && !PSLVERR && !m_write;
                end
            end
            check("psel",    32'(PSEL),      32'(e_psel));
            check("penable", 32'(PENABLE),   32'(e_pen));
            check("hready",  32'(HREADYOUT), 32'(e_hrdy));
            check("hresp",   32'(HRESP),     32'(e_hresp));
            check("paddr",   PADDR,          m_addr);
            check("pwrite",  32'(PWRITE),    32'(m_write));
            check("pwdata",  PWDATA,         HWDATA);
            if (e_rd_done) check("hrdata", HRDATA, PRDATA);

            // Advance the model by one clock.
            take = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);
            if (m_active && !m_in_access) begin
                m_in_access = 1'b1;
            end else if (m_active && !PREADY) begin
                // Slave is still waiting, so the model holds its state.
            end else if (m_active && PSLVERR) begin
                m_active    = 1'b0;
                m_in_access = 1'b0;
                m_err_left  = 2;
            end else if (m_err_left == 2) begin
                m_err_left = 1;
            end else begin
                m_err_left  = 0;
                m_active    = 1'b0;
                m_in_access = 1'b0;
                if (take) begin
                    m_active = 1'b1;
                    m_addr   = HADDR;
                    m_write  = HWRITE;
                end
            end
        end
    end

    // One bus cycle: drive just after the rising edge, then leave 1 time unit for settling.
    task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd, input logic rdy,
                       input logic err, input logic [31:0] rd);
        @(posedge HCLK);
        #1;
        HSEL    = sel;
        HTRANS  = tr;
        HADDR   = addr;
        HWRITE  = wr;
        HWDATA  = wd;
        HREADY  = 1'b1;
        PREADY  = rdy;
        PSLVERR = err;
        PRDATA  = rd;
        #1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HADDR   = 32'h0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HREADY  = 1'b1;
        HWDATA  = 32'h0;
        PRDATA  = 32'h0;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Zero-wait write to slot 3.
        cyc(1'b1, 2'b10, 32'h4000_0304, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wr_t0_hready", 32'(HREADYOUT), 32'h1);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'hA5, 1'b1, 1'b0, 32'h0);
        check("wr_t1_psel",    32'(PSEL),      32'h0008);
        check("wr_t1_penable", 32'(PENABLE),   32'h0);
        check("wr_t1_pwdata",  PWDATA,         32'hA5);
        check("wr_t1_hready",  32'(HREADYOUT), 32'h0);
        check("wr_t1_paddr",   PADDR,          32'h4000_0304);
        check("wr_t1_pwrite",  32'(PWRITE),    32'h1);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'hA5, 1'b1, 1'b0, 32'h0);
        check("wr_t2_psel",    32'(PSEL),      32'h0008);
        check("wr_t2_penable", 32'(PENABLE),   32'h1);
        check("wr_t2_hready",  32'(HREADYOUT), 32'h1);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wr_t3_psel", 32'(PSEL), 32'h0);

        // Read from slot 5 with three wait cycles: HREADYOUT stays low for four cycles.
        cyc(1'b1, 2'b10, 32'h4000_0500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5A);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5A);
            check("rdw_wait_hready", 32'(HREADYOUT), 32'h0);
        end
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5A);
        check("rdw_done_hready", 32'(HREADYOUT), 32'h1);
        check("rdw_done_hrdata", HRDATA,         32'h5A);
        check("rdw_done_psel",   32'(PSEL),      32'h0020);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Slave error on slot 7.
        cyc(1'b1, 2'b10, 32'h4000_0700, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        check("err_setup_hresp", 32'(HRESP), 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        check("err_acc_hresp",  32'(HRESP),     32'h1);
        check("err_acc_hready", 32'(HREADYOUT), 32'h0);
        check("err_acc_psel",   32'(PSEL),      32'h0080);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("err1_hresp",  32'(HRESP),     32'h1);
        check("err1_hready", 32'(HREADYOUT), 32'h0);
        check("err1_psel",   32'(PSEL),      32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("err2_hresp",  32'(HRESP),     32'h1);
        check("err2_hready", 32'(HREADYOUT), 32'h1);
        check("err2_psel",   32'(PSEL),      32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("err_idle_hresp", 32'(HRESP), 32'h0);

        // Back-to-back: write to slot 2, then read from slot 5 with no idle gap.
        cyc(1'b1, 2'b10, 32'h4000_0200, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h11, 1'b1, 1'b0, 32'h0);
        check("b2b_t1_psel", 32'(PSEL), 32'h0004);
        cyc(1'b1, 2'b10, 32'h4000_0500, 1'b0, 32'h11, 1'b1, 1'b0, 32'h0);
        check("b2b_t2_psel",   32'(PSEL),      32'h0004);
        check("b2b_t2_hready", 32'(HREADYOUT), 32'h1);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h77);
        check("b2b_t3_psel",    32'(PSEL),    32'h0020);
        check("b2b_t3_penable", 32'(PENABLE), 32'h0);
        check("b2b_t3_paddr",   PADDR,        32'h4000_0500);
        check("b2b_t3_pwrite",  32'(PWRITE),  32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h77);
        check("b2b_t4_penable", 32'(PENABLE),   32'h1);
        check("b2b_t4_hready",  32'(HREADYOUT), 32'h1);
        check("b2b_t4_hrdata",  HRDATA,         32'h77);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // BUSY transfers and deselected transfers are ignored.
        cyc(1'b1, 2'b01, 32'h4000_0300, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 2'b10, 32'h4000_0300, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("busy_psel",   32'(PSEL),      32'h0);
        check("busy_hready", 32'(HREADYOUT), 32'h1);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("nosel_psel",   32'(PSEL),      32'h0);
        check("nosel_hready", 32'(HREADYOUT), 32'h1);

        // Reset while the slave is stalling in ACCESS, between clock edges.
        cyc(1'b1, 2'b10, 32'h4000_0904, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h3C, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 1'b0, 32'h3C, 1'b0, 1'b0, 32'h0);
        check("mid_penable", 32'(PENABLE),   32'h1);
        check("mid_hready",  32'(HREADYOUT), 32'h0);
        #1 HRESETn = 1'b0;
        #1;
        check("async_psel",    32'(PSEL),      32'h0);
        check("async_penable", 32'(PENABLE),   32'h0);
        check("async_hready",  32'(HREADYOUT), 32'h1);
        check("async_hresp",   32'(HRESP),     32'h0);
        check("async_paddr",   PADDR,          32'h0);
        check("async_pwrite",  32'(PWRITE),    32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Random traffic. Occasionally reset is pulsed for part of a cycle.
        repeat (4000) begin
            @(posedge HCLK);
            #1;
            HRESETn = 1'b1;
            HSEL    = ($urandom_range(0, 3) != 0);
            HTRANS  = 2'($urandom_range(0, 3));
            HADDR   = $urandom;
            HWRITE  = 1'($urandom_range(0, 1));
            HSIZE   = 3'($urandom_range(0, 7));
            HREADY  = ($urandom_range(0, 4) != 0);
            HWDATA  = $urandom;
            PRDATA  = $urandom;
            PREADY  = ($urandom_range(0, 9) < 7);
            PSLVERR = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 HRESETn = 1'b0;
            end
        end
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
